// File: rtl/warp_pkg.sv
// Shared types, defaults and width helpers for the warp mask sequencer family.
package warp_pkg;

    localparam int NUM_THREADS_DEF = 8;
    localparam int ISSUE_WIDTH_DEF = 2;

    // Width of the hierarchical group code for a warp of nt lanes.
    function automatic int code_w(input int nt);
        return 2 * ($clog2(nt) - 1);
    endfunction

    // Width of the beat index; kept at least 1 so ports never collapse.
    function automatic int grp_w(input int nt, input int iw);
        return ((nt / iw) > 1) ? $clog2(nt / iw) : 1;
    endfunction

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

endpackage

// File: rtl/thread_mask_code_decoder.sv
// Combinational decode of a hierarchical group code into a per-lane active mask.
// Leading ones select the split depth k, a 0 terminates (unless k is at its cap),
// and the next k bits pick which of the 2^k equal lane groups is active.
module thread_mask_code_decoder
    import warp_pkg::*;
#(
    parameter int NUM_THREADS = NUM_THREADS_DEF,
    parameter int CODE_W      = code_w(NUM_THREADS)
) (
    input  logic [CODE_W-1:0]      code,
    output logic [NUM_THREADS-1:0] mask
);

    localparam int L = $clog2(NUM_THREADS);

    int  k;
    int  g;
    int  start;
    int  idx;
    logic done;

    // Count leading ones, extract the group index, then light the selected lanes.
    always_comb begin
        k     = 0;
        g     = 0;
        start = 0;
        idx   = 0;
        done  = 1'b0;
        mask  = '0;
        for (int j = 0; j < L - 1; j++) begin
            if (!done) begin
                if (code[CODE_W-1-j]) begin
                    k = k + 1;
                end else begin
                    done = 1'b1;
                end
            end
        end
        // Skip the terminator bit unless depth is capped (no terminator then).
        start = (k < L - 1) ? k + 1 : k;
        for (int j = 0; j < L - 1; j++) begin
            if (j < k) begin
                idx = CODE_W - 1 - (start + j);
                if (idx >= 0) begin
                    g = (g << 1) | (code[idx] ? 1 : 0);
                end
            end
        end
        // Lane i belongs to group i / 2^(L-k).
        for (int i = 0; i < NUM_THREADS; i++) begin
            mask[i] = ((i >> (L - k)) == g);
        end
    end

endmodule

// File: rtl/warp_mask_sequencer.sv
// Accepts a warp issue request (group code or raw bitmap), latches its active
// mask and streams it out in ISSUE_WIDTH-lane beats, skipping empty beats.
module warp_mask_sequencer
    import warp_pkg::*;
#(
    parameter int NUM_THREADS = NUM_THREADS_DEF,
    parameter int ISSUE_WIDTH = ISSUE_WIDTH_DEF,
    parameter int WARP_ID_W   = 3,
    parameter int CODE_W      = code_w(NUM_THREADS)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic                                      in_raw,
    input  logic [CODE_W-1:0]                         in_code,
    input  logic [NUM_THREADS-1:0]                    in_raw_mask,
    input  logic [WARP_ID_W-1:0]                      in_warp_id,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [ISSUE_WIDTH-1:0]                    out_lanes,
    output logic [grp_w(NUM_THREADS, ISSUE_WIDTH)-1:0] out_group,
    output logic                                      out_last,
    output logic [WARP_ID_W-1:0]                      out_warp_id,
    output logic [NUM_THREADS-1:0]                    out_active_mask,
    output logic                                      empty_drop
);

    localparam int NB    = NUM_THREADS / ISSUE_WIDTH;
    localparam int GRP_W = grp_w(NUM_THREADS, ISSUE_WIDTH);

    state_e                 state_q, state_d;
    logic [NUM_THREADS-1:0] mask_q, mask_d;
    logic [WARP_ID_W-1:0]   warp_id_q, warp_id_d;
    logic [GRP_W-1:0]       ptr_q, ptr_d;
    logic                   drop_q, drop_d;

    logic [NUM_THREADS-1:0] dec_mask;
    logic [NUM_THREADS-1:0] new_mask;
    logic [NB-1:0]          new_nz;
    logic [NB-1:0]          cur_nz;
    logic [NB-1:0]          nz_above;
    logic                   last_beat;

    // Lowest set bit of a slice-valid vector.
    function automatic logic [GRP_W-1:0] lowest_set(input logic [NB-1:0] v);
        lowest_set = '0;
        for (int b = NB - 1; b >= 0; b--) begin
            if (v[b]) lowest_set = GRP_W'(b);
        end
    endfunction

    thread_mask_code_decoder #(
        .NUM_THREADS (NUM_THREADS),
        .CODE_W      (CODE_W)
    ) u_decoder (
        .code (in_code),
        .mask (dec_mask)
    );

    // Slice-valid vectors for the incoming and held masks, plus the "above pointer" view.
    always_comb begin
        new_mask = in_raw ? in_raw_mask : dec_mask;
        new_nz   = '0;
        cur_nz   = '0;
        nz_above = '0;
        for (int b = 0; b < NB; b++) begin
            new_nz[b]   = |new_mask[b*ISSUE_WIDTH +: ISSUE_WIDTH];
            cur_nz[b]   = |mask_q[b*ISSUE_WIDTH +: ISSUE_WIDTH];
            nz_above[b] = cur_nz[b] && (b > int'(ptr_q));
        end
        last_beat = ~|nz_above;
    end

    // Next-state logic: accept in IDLE, step through nonzero beats in ISSUE.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        warp_id_d = warp_id_q;
        ptr_d     = ptr_q;
        drop_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mask_d    = new_mask;
                    warp_id_d = in_warp_id;
                    if (|new_mask) begin
                        state_d = ISSUE;
                        ptr_d   = lowest_set(new_nz);
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (out_ready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        ptr_d = lowest_set(nz_above);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            warp_id_q <= '0;
            ptr_q     <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            warp_id_q <= warp_id_d;
            ptr_q     <= ptr_d;
            drop_q    <= drop_d;
        end
    end

    // Beat outputs are views of the held request; gated so IDLE shows no beat.
    always_comb begin
        in_ready        = (state_q == IDLE);
        out_valid       = (state_q == ISSUE);
        out_group       = ptr_q;
        out_lanes       = out_valid ? mask_q[int'(ptr_q)*ISSUE_WIDTH +: ISSUE_WIDTH] : '0;
        out_last        = out_valid && last_beat;
        out_warp_id     = warp_id_q;
        out_active_mask = mask_q;
        empty_drop      = drop_q;
    end

endmodule

// File: doc/warp_mask_sequencer.md
Name: warp_mask_sequencer

Overview:
Parametrised successor to the fixed 8-thread mask decoder. Accepts one warp issue request per handshake, carrying either a hierarchical group code or a raw per-lane bitmap. Converts it to a NUM_THREADS-bit active mask, then issues it over several cycles in ISSUE_WIDTH-lane beats, skipping all-inactive beats. Sits between the warp scheduler and a datapath narrower than the warp.

Parameters:
NUM_THREADS, 8, lanes per warp; must be a power of 2 and at least 4.
ISSUE_WIDTH, 2, lanes per issued beat; must be a power of 2 that divides NUM_THREADS.
WARP_ID_W, 3, width of the warp tag passed through.
CODE_W, 2*(log2(NUM_THREADS)-1), derived width of the group code; do not override.

Ports:
clk  in  1  clock; all logic is rising-edge.
rst_n  in  1  synchronous, active-low reset.
in_valid  in  1  request valid.
in_ready  out  1  block can accept a request.
in_raw  in  1  1 = use in_raw_mask; 0 = decode in_code.
in_code  in  CODE_W  hierarchical group code.
in_raw_mask  in  NUM_THREADS  per-lane bitmap; bit i = lane i.
in_warp_id  in  WARP_ID_W  tag for the request.
out_valid  out  1  beat valid.
out_ready  in  1  consumer accepts the beat.
out_lanes  out  ISSUE_WIDTH  active lanes within the beat.
out_group  out  log2(NUM_THREADS/ISSUE_WIDTH)  beat index; lanes are [out_group*ISSUE_WIDTH +: ISSUE_WIDTH].
out_last  out  1  final non-empty beat of the request.
out_warp_id  out  WARP_ID_W  tag of the request being issued.
out_active_mask  out  NUM_THREADS  full decoded mask, held for the whole request.
empty_drop  out  1  one-cycle pulse when a request with an all-zero mask is dropped.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE; in_ready=1.
  - out_valid=0, out_last=0, empty_drop=0.
  - out_lanes, out_group, out_warp_id and out_active_mask all go to 0.
  - Reset mid-request discards the request; no further beats are issued.
- Group-code decoding (L = log2(NUM_THREADS)):
  - k = number of leading ones in in_code from the MSB, capped at L-1.
  - If k < L-1, the next bit is a 0 terminator.
  - The following k bits are the group index g, MSB-first. Remaining LSBs are don't-care.
  - Mask = ones on lanes [g*(NUM_THREADS>>k) +: NUM_THREADS>>k].
  - For NUM_THREADS=8: 0xxx→0xFF, 100x→0x0F, 101x→0xF0, 1100→0x03, 1101→0x0C, 1110→0x30, 1111→0xC0.
  - A decoded mask is never empty.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, register the mask and in_warp_id.
    - Mask nonzero: go to ISSUE; out_valid=1 on the next cycle. Latency is 1 cycle from the accept edge.
    - Mask zero: stay in IDLE, pulse empty_drop on the next cycle, issue no beats.
  - ISSUE: in_ready=0.
    - Pointer p = lowest beat index ≥ the current beat whose ISSUE_WIDTH slice of the mask is nonzero.
    - out_lanes = that slice; out_group = p.
    - out_last = 1 when no nonzero slice exists above p.
    - On out_valid&out_ready with out_last=0: advance to the next nonzero slice in one cycle, with no bubble.
    - On out_valid&out_ready with out_last=1: go to IDLE. out_valid=0 and in_ready=1 on the next cycle (one-cycle bubble between requests, by design).
- Backpressure: while out_valid=1 and out_ready=0, all out_* signals hold stable.
- out_active_mask and out_warp_id are constant from the first beat to the last, and keep their last value in IDLE.
- Simultaneous events:
  - in_valid while in ISSUE is ignored; the upstream must hold the request.
  - out_ready while out_valid=0 has no effect.
- Beat pointer wrap-around cannot occur; the sequence always ends at the highest nonzero slice.

Decomposition:
- Shared package warp_pkg holds:
  - NUM_THREADS and ISSUE_WIDTH defaults.
  - Helper functions for CODE_W and the group-index width.
  - The state enum {IDLE, ISSUE}.
- Sub-module thread_mask_code_decoder: purely combinational, parametrised by NUM_THREADS, maps code to mask. It is reused by other scheduler blocks.
- Next-nonzero-slice search stays inline as a priority encoder over a masked slice-valid vector.

Test Plan (NUM_THREADS=8, ISSUE_WIDTH=2, out_ready=1 unless stated):
- in_code=4'b0000 → beats with group 0,1,2,3, each with lanes 2'b11, on consecutive cycles; out_last only on group 3; out_active_mask=0xFF; in_ready=1 one cycle after the last beat.
- in_code=4'b1101 → single beat: group 1, lanes 2'b11, out_last=1, mask 0x0C. Then in_code=4'b1010 → groups 2 and 3, mask 0xF0.
- in_raw=1, in_raw_mask=8'b1000_0101 → group0 lanes 01, group1 lanes 01, group3 lanes 10 with out_last=1; group 2 is skipped, giving exactly 3 beats.
- in_code=4'b0000 with out_ready=0 for 3 cycles during group 1 → out_group=1, out_lanes=11 and out_last=0 stay stable; group 2 follows one cycle after out_ready rises.
- in_raw=1, in_raw_mask=0x00 → no out_valid; empty_drop=1 for exactly one cycle; in_ready stays 1.
- rst_n=0 for one edge during the group-2 beat → out_valid=0, in_ready=1 and out_active_mask=0 next cycle; no residual beats after reset release.
